// File: rtl/bitty_pkg.sv
// ---------------------------------------------------------------------------
// bitty_pkg
// Shared definitions for the bitty system blocks.
//   arb_state_t : state encoding of the UART transmit arbiter
//   REQ_FETCH   : requester index of the instruction-fetch unit
//   REQ_BITTY   : requester index of the bitty core store/print path
//   onehot_to_idx : converts a one-hot vector (up to 8 bits) to its index
// ---------------------------------------------------------------------------
package bitty_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_WAIT    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    localparam int REQ_FETCH = 0;
    localparam int REQ_BITTY = 1;

    // A zero vector maps to index 0; callers only use this on a valid grant.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin selector. Returns the first set request bit found
// when searching upward from rr_ptr, wrapping past the top back to index 0.
// Ports:
//   req    in  NUM_REQ  request vector
//   rr_ptr in  PTR_W    index with the highest priority this round
//   winner out NUM_REQ  one-hot winner, all zero when req is zero
// ---------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int NUM_REQ = 2,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic [NUM_REQ-1:0] req_rot;
    logic [NUM_REQ-1:0] pick_rot;

    // Rotate requests so rr_ptr lands on bit 0, isolate the lowest set bit
    // with x & -x, then rotate the one-hot result back into place.
    always_comb begin
        req_rot  = NUM_REQ'({req, req} >> rr_ptr);
        pick_rot = req_rot & (~req_rot + NUM_REQ'(1));
        winner   = NUM_REQ'(({pick_rot, pick_rot} << rr_ptr) >> NUM_REQ);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin owner of the single UART transmitter. One requester at a time
// is granted the transmitter for one byte; the grant is held until the UART
// reports tx_done, then the owner receives a one-cycle done_out pulse.
// Optional watchdog: define UART_TX_ARB_TIMEOUT_EN to abandon a transfer
// after TIMEOUT_CYCLES cycles in WAIT and raise a sticky timeout_err.
// Ports:
//   clk         in  system clock
//   reset       in  synchronous, active-high reset
//   req         in  per-requester level request, held until done_out
//   req_data    in  packed bytes, requester i at [i*DATA_W +: DATA_W]
//   grant       out one-hot current owner, zero when idle
//   done_out    out one-cycle completion pulse to the owner
//   tx_en       out one-cycle start pulse to uart_module
//   tx_data     out byte presented to uart_module
//   tx_done     in  UART transmit-complete pulse
//   busy        out high whenever the arbiter is not idle
//   timeout_err out sticky watchdog flag (0 without the watchdog)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import bitty_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done_out,
    output logic                      tx_en,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ <= REQ_BITTY || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be between 2 and 8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must fit the 16-bit watchdog");
    end

    arb_state_t          state, state_nxt;
    logic [NUM_REQ-1:0]  winner;
    logic [NUM_REQ-1:0]  grant_nxt, done_nxt;
    logic                tx_en_nxt, busy_nxt;
    logic [DATA_W-1:0]   tx_data_nxt, win_data;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt, owner_ptr;
    logic [7:0]          grant_ext;
    logic [2:0]          owner_idx;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner)
    );

    // Byte of the winning requester, selected by OR-folding under the one-hot.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                win_data = win_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next round starts just above the current owner, wrapping at NUM_REQ.
    always_comb begin
        grant_ext                = '0;
        grant_ext[NUM_REQ-1:0]   = grant;
        owner_idx                = onehot_to_idx(grant_ext);
        owner_ptr                = (owner_idx == 3'(NUM_REQ-1)) ? '0
                                                                : PTR_W'(owner_idx + 3'd1);
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt, wd_cnt_nxt;
    logic        timeout_nxt;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        done_nxt    = '0;
        tx_en_nxt   = 1'b0;
        tx_data_nxt = tx_data;
        rr_ptr_nxt  = rr_ptr;
`ifdef UART_TX_ARB_TIMEOUT_EN
        wd_cnt_nxt  = wd_cnt;
        timeout_nxt = timeout_err;
`endif
        case (state)
            ARB_IDLE: begin
                if (|req) begin
                    grant_nxt   = winner;
                    tx_data_nxt = win_data;
                    tx_en_nxt   = 1'b1;
                    state_nxt   = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_nxt = ARB_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
                wd_cnt_nxt = '0;
`endif
            end
            ARB_WAIT: begin
                if (tx_done) begin
                    done_nxt   = grant;
                    grant_nxt  = '0;
                    rr_ptr_nxt = owner_ptr;
                    state_nxt  = ARB_RELEASE;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                // Abandon the byte silently; the pointer still advances so a
                // stuck UART cannot pin priority on one requester.
                else if (wd_cnt == WD_LAST) begin
                    grant_nxt   = '0;
                    rr_ptr_nxt  = owner_ptr;
                    timeout_nxt = 1'b1;
                    state_nxt   = ARB_RELEASE;
                end else begin
                    wd_cnt_nxt = wd_cnt + 16'd1;
                end
`endif
            end
            ARB_RELEASE: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
        busy_nxt = (state_nxt != ARB_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            done_out <= '0;
            tx_en    <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            rr_ptr   <= PTR_W'(REQ_FETCH);
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            done_out <= done_nxt;
            tx_en    <= tx_en_nxt;
            tx_data  <= tx_data_nxt;
            busy     <= busy_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt      <= wd_cnt_nxt;
            timeout_err <= timeout_nxt;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NUM_REQ=2, DATA_W=8). Define
// UART_TX_ARB_TIMEOUT_EN to also exercise the watchdog with a 50-cycle limit.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 8;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO_CYC  = 50;
`else
    localparam int TO_CYC  = 65535;
`endif

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done_out;
    logic                      tx_en;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_done;
    logic                      busy;
    logic                      timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .done_out    (done_out),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] grant;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        int         done_delay;
    } vec_t;

    exp_t       tx_q[$];
    logic [1:0] done_q[$];
    exp_t       mon_e;
    int         n_checks  = 0;
    int         n_fail    = 0;
    int         tx_seen   = 0;
    int         model_ptr = 0;
    vec_t       vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every tx_en must match the next queued byte/owner, and
    // every done_out must match the owner of the oldest issued byte.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (tx_en) begin
                tx_seen++;
                if (tx_q.size() == 0) begin
                    checkOutput("unexpected_tx_en", 32'(tx_en), 32'd0);
                end else begin
                    mon_e = tx_q.pop_front();
                    checkOutput("tx_grant", 32'(grant), 32'(mon_e.grant));
                    checkOutput("tx_data", 32'(tx_data), 32'(mon_e.data));
                    done_q.push_back(mon_e.grant);
                end
            end
            if (done_out != '0) begin
                if (done_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'(done_out), 32'd0);
                end else begin
                    checkOutput("done_owner", 32'(done_out), 32'(done_q.pop_front()));
                end
            end
        end
    end

    // Drives one request pattern and serves every requester in it. The
    // expected grant order comes from a circular scan starting at model_ptr.
    task automatic applyStimulus(input vec_t v);
        int         order[$];
        logic [1:0] r;
        int         idx;
        int         cyc;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (model_ptr + k) % NUM_REQ;
            if (v.req[idx]) order.push_back(idx);
        end
        foreach (order[j]) begin
            tx_q.push_back('{grant: 2'(1 << order[j]), data: (order[j] == 1) ? v.d1 : v.d0});
        end
        if (order.size() > 0) model_ptr = (order[order.size()-1] + 1) % NUM_REQ;
        req_data = {v.d1, v.d0};
        r        = v.req;
        req      = r;
        foreach (order[j]) begin
            tick();
            cyc = 1;
            while (!tx_en && cyc < 50) begin
                tick();
                cyc++;
            end
            if (!tx_en) begin
                checkOutput("tx_en_wait_expired", 32'd0, 32'd1);
                req = '0;
                return;
            end
            if (j == 0) checkOutput("issue_latency", cyc, 32'd1);
            repeat (v.done_delay) tick();
            checkOutput("wait_grant_held", 32'(grant), 32'(1 << order[j]));
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            checkOutput("release_done", 32'(done_out), 32'(1 << order[j]));
            checkOutput("release_grant", 32'(grant), 32'd0);
            r[order[j]] = 1'b0;
            req = r;
        end
        tick();
        tick();
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int base_seen;
        int cyc;
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        tx_done  = 1'b0;

        vecs[0] = '{2'b11, 8'h11, 8'h22, 3};
        vecs[1] = '{2'b01, 8'hA5, 8'h00, 20};
        vecs[2] = '{2'b11, 8'h33, 8'h44, 2};
        vecs[3] = '{2'b10, 8'h00, 8'h55, 1};
        vecs[4] = '{2'b11, 8'h66, 8'h77, 5};
        vecs[5] = '{2'b01, 8'h88, 8'h00, 1};

        repeat (3) tick();
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_done", 32'(done_out), 32'd0);
        checkOutput("rst_tx_en", 32'(tx_en), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d req=%b", i, vecs[i].req);
            applyStimulus(vecs[i]);
        end

        // Requester 0 withdraws during WAIT; the byte still completes once.
        $display("[TB] request withdrawn mid-transfer");
        base_seen = tx_seen;
        tx_q.push_back('{grant: 2'b01, data: 8'h99});
        req_data = {8'h00, 8'h99};
        req = 2'b01;
        tick();
        checkOutput("drop_tx_en", 32'(tx_en), 32'd1);
        tick();
        req = 2'b00;
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("drop_done", 32'(done_out), 32'd1);
        model_ptr = 1;
        repeat (6) tick();
        checkOutput("drop_single_issue", tx_seen - base_seen, 32'd1);
        checkOutput("drop_busy", 32'(busy), 32'd0);

        // Stray tx_done while idle must do nothing.
        $display("[TB] spurious tx_done in IDLE");
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("spur_busy", 32'(busy), 32'd0);
        checkOutput("spur_done", 32'(done_out), 32'd0);
        checkOutput("spur_grant", 32'(grant), 32'd0);
        tick();
        checkOutput("spur_busy2", 32'(busy), 32'd0);
        checkOutput("spur_done2", 32'(done_out), 32'd0);

        // Reset in WAIT, then a late tx_done from the still-running UART.
        $display("[TB] reset during WAIT");
        tx_q.push_back('{grant: 2'b10, data: 8'hC3});
        req_data = {8'hC3, 8'h00};
        req = 2'b10;
        tick();
        tick();
        checkOutput("wait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        req = 2'b00;
        tick();
        reset = 1'b0;
        tx_q.delete();
        done_q.delete();
        model_ptr = 0;
        checkOutput("mid_rst_grant", 32'(grant), 32'd0);
        checkOutput("mid_rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("late_done_busy", 32'(busy), 32'd0);
        checkOutput("late_done_out", 32'(done_out), 32'd0);
        tick();
        checkOutput("late_done_busy2", 32'(busy), 32'd0);
        checkOutput("late_done_grant", 32'(grant), 32'd0);

        // Pointer was reset, so contention must start with requester 0 again.
        applyStimulus('{2'b11, 8'hD0, 8'hD1, 2});

`ifdef UART_TX_ARB_TIMEOUT_EN
        // UART never answers: watchdog releases after TO_CYC cycles in WAIT.
        $display("[TB] watchdog timeout");
        tx_q.push_back('{grant: 2'b01, data: 8'h5A});
        req_data = {8'h00, 8'h5A};
        req = 2'b01;
        tick();
        checkOutput("to_tx_en", 32'(tx_en), 32'd1);
        cyc = 0;
        while (grant != '0 && cyc < 200) begin
            tick();
            cyc++;
        end
        req = 2'b00;
        done_q.delete();
        model_ptr = 1;
        checkOutput("to_release_cycles", cyc, TO_CYC + 1);
        checkOutput("to_err", 32'(timeout_err), 32'd1);
        checkOutput("to_no_done", 32'(done_out), 32'd0);
        repeat (3) tick();
        checkOutput("to_err_sticky", 32'(timeout_err), 32'd1);
        applyStimulus('{2'b01, 8'h6B, 8'h00, 2});
        checkOutput("to_err_sticky2", 32'(timeout_err), 32'd1);
`else
        cyc = 0;
        checkOutput("no_watchdog_err", 32'(timeout_err), 32'(cyc));
`endif

        checkOutput("tx_queue_drained", tx_q.size(), 32'd0);
        checkOutput("done_queue_drained", done_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
